// File: rtl/shared_bus_master_if.sv
// Request/response and shared-bus signal bundle for shared_bus_master.
// master = the bus-master block itself, slave = the L2 side plus bus fabric.
interface shared_bus_master_if;
    logic         req_valid;
    logic         req_ready;
    logic [7:0]   req_op;
    logic [31:0]  req_addr;
    logic [511:0] req_data;
    logic         resp_valid;
    logic [1:0]   resp_snoop;
    logic [511:0] resp_data;
    logic         bus_req;
    logic         bus_grant;
    logic [7:0]   bus_op;
    logic [31:0]  bus_addr;
    logic [511:0] bus_data_out;
    logic [511:0] bus_data_in;
    logic [1:0]   snoop_in;

    modport master (
        input  req_valid, req_op, req_addr, req_data,
        output req_ready, resp_valid, resp_snoop, resp_data,
        output bus_req, bus_op, bus_addr, bus_data_out,
        input  bus_grant, bus_data_in, snoop_in
    );

    modport slave (
        output req_valid, req_op, req_addr, req_data,
        input  req_ready, resp_valid, resp_snoop, resp_data,
        input  bus_req, bus_op, bus_addr, bus_data_out,
        output bus_grant, bus_data_in, snoop_in
    );
endinterface

// File: rtl/shared_bus_master.sv
// Snooping shared-bus master: arbitrates, issues one address phase, samples snoop, moves data.
// Define SNOOP_RETRY_EN to back off and re-issue reads/RFOs that see HITM (up to MAX_RETRY times).
module shared_bus_master #(
    parameter int unsigned SNOOP_WAIT = 2,
    parameter int unsigned MAX_RETRY  = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    shared_bus_master_if.master sbm
);

    localparam logic [7:0] OP_R = 8'h52;
    localparam logic [7:0] OP_W = 8'h57;
    localparam logic [7:0] OP_M = 8'h4D;
    localparam logic [7:0] OP_I = 8'h49;

    localparam logic [1:0] SN_HITM    = 2'b01;
    localparam logic [1:0] SN_NOHIT   = 2'b10;
    localparam logic [1:0] SN_ILLEGAL = 2'b11;

    // Out-of-range parameters collapse the snoop window to a single cycle.
    localparam bit PARAMS_OK = (SNOOP_WAIT >= 1) && (SNOOP_WAIT <= 15) &&
                               (MAX_RETRY >= 1) && (MAX_RETRY <= 7);
    localparam logic [3:0] WAIT_LAST = PARAMS_OK ? 4'(SNOOP_WAIT - 1) : 4'd0;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        ADDR,
        SNOOP,
`ifdef SNOOP_RETRY_EN
        BACKOFF,
`endif
        DATA,
        RESP
    } state_t;

    state_t       state_q;
    logic [7:0]   op_q;
    logic [31:0]  addr_q;
    logic [511:0] data_q;
    logic [3:0]   wait_q;
    logic         req_ready_q;
    logic         resp_valid_q;
    logic [1:0]   resp_snoop_q;
    logic [511:0] resp_data_q;
    logic         bus_req_q;
    logic [7:0]   bus_op_q;
    logic [31:0]  bus_addr_q;
    logic [511:0] bus_data_out_q;
    logic [1:0]   snoop_d;
    logic         is_read;
`ifdef SNOOP_RETRY_EN
    localparam logic [2:0] RETRY_MAX = 3'(MAX_RETRY);
    logic [2:0]   retry_q;
`endif

    function automatic logic op_legal(input logic [7:0] op);
        return (op == OP_R) || (op == OP_W) || (op == OP_M) || (op == OP_I);
    endfunction

    // An undriven/contended snoop bus (11) is taken as no hit.
    always_comb begin
        snoop_d = (sbm.snoop_in == SN_ILLEGAL) ? SN_NOHIT : sbm.snoop_in;
        is_read = (op_q == OP_R) || (op_q == OP_M);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            op_q           <= '0;
            addr_q         <= '0;
            data_q         <= '0;
            wait_q         <= '0;
            req_ready_q    <= 1'b1;
            resp_valid_q   <= 1'b0;
            resp_snoop_q   <= SN_NOHIT;
            resp_data_q    <= '0;
            bus_req_q      <= 1'b0;
            bus_op_q       <= '0;
            bus_addr_q     <= '0;
            bus_data_out_q <= '0;
`ifdef SNOOP_RETRY_EN
            retry_q        <= '0;
`endif
        end else begin
            resp_valid_q   <= 1'b0;
            bus_op_q       <= '0;
            bus_addr_q     <= '0;
            bus_data_out_q <= '0;
            unique case (state_q)
                IDLE: begin
                    if (sbm.req_valid) begin
                        op_q        <= sbm.req_op;
                        addr_q      <= sbm.req_addr;
                        data_q      <= sbm.req_data;
                        req_ready_q <= 1'b0;
`ifdef SNOOP_RETRY_EN
                        retry_q     <= '0;
`endif
                        if (op_legal(sbm.req_op)) begin
                            state_q   <= ARB;
                            bus_req_q <= 1'b1;
                        end else begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_snoop_q <= SN_ILLEGAL;
                        end
                    end
                end
                ARB: begin
                    if (sbm.bus_grant) begin
                        state_q    <= ADDR;
                        bus_op_q   <= op_q;
                        bus_addr_q <= addr_q;
                    end
                end
                ADDR: begin
                    state_q <= SNOOP;
                    wait_q  <= WAIT_LAST;
                end
                SNOOP: begin
                    if (wait_q != '0) begin
                        wait_q <= wait_q - 4'd1;
                    end else begin
                        resp_snoop_q <= snoop_d;
`ifdef SNOOP_RETRY_EN
                        if (snoop_d == SN_HITM && is_read && retry_q < RETRY_MAX) begin
                            state_q   <= BACKOFF;
                            wait_q    <= WAIT_LAST;
                            bus_req_q <= 1'b0;
                            retry_q   <= retry_q + 3'd1;
                        end else
`endif
                        if (op_q == OP_I) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                        end else begin
                            state_q <= DATA;
                            if (op_q == OP_W) bus_data_out_q <= data_q;
                        end
                    end
                end
`ifdef SNOOP_RETRY_EN
                BACKOFF: begin
                    if (wait_q != '0) begin
                        wait_q <= wait_q - 4'd1;
                    end else begin
                        state_q   <= ARB;
                        bus_req_q <= 1'b1;
                    end
                end
`endif
                DATA: begin
                    state_q      <= RESP;
                    resp_valid_q <= 1'b1;
                    if (is_read) resp_data_q <= sbm.bus_data_in;
                end
                RESP: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                    bus_req_q   <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sbm.req_ready    = req_ready_q;
    assign sbm.resp_valid   = resp_valid_q;
    assign sbm.resp_snoop   = resp_snoop_q;
    assign sbm.resp_data    = resp_data_q;
    assign sbm.bus_req      = bus_req_q;
    assign sbm.bus_op       = bus_op_q;
    assign sbm.bus_addr     = bus_addr_q;
    assign sbm.bus_data_out = bus_data_out_q;

endmodule

// File: tb/tb_shared_bus_master.sv
// Scoreboard bench for shared_bus_master: directed transactions, monitor pops expected responses.
// Expectations follow SNOOP_RETRY_EN when the bench is built with it.
module tb_shared_bus_master;

    localparam int unsigned SW       = 2;
    localparam int unsigned MR       = 3;
    localparam int          BASE_LAT = 3 + SW;

    typedef struct {
        logic [1:0]   snoop;
        logic [511:0] data;
        int           lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    shared_bus_master_if bus_if ();

    shared_bus_master #(.SNOOP_WAIT(SW), .MAX_RETRY(MR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sbm   (bus_if.master)
    );

    exp_t       exp_q[$];
    logic [1:0] snoop_script[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int addr_phases = 0;
    int wdata_cycles = 0;
    int bk_low = 0;
    int req_cycles = 0;
    logic [7:0]   cur_op = '0;
    logic [31:0]  cur_addr = '0;
    logic [511:0] cur_data = '0;
    logic grant_main = 1'b1;
    logic grant_drop = 1'b0;
    logic grant_dropped = 1'b0;

    assign bus_if.bus_grant = grant_main && !grant_dropped;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Bus responder + scoreboard monitor; all sampling on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (!grant_drop) grant_dropped = 1'b0;
        if (rst_n) begin
            if (bus_if.req_valid && bus_if.req_ready) acc_cyc = cyc + 1;
            if (bus_if.bus_req) req_cycles++;
            if (!bus_if.bus_req && !bus_if.req_ready && !bus_if.resp_valid) bk_low++;
            if (bus_if.bus_op != 8'h00) begin
                addr_phases++;
                chk("addr_op", bus_if.bus_op, cur_op);
                chk("addr_addr", bus_if.bus_addr, cur_addr);
                if (snoop_script.size() != 0) bus_if.snoop_in = snoop_script.pop_front();
                else bus_if.snoop_in = 2'b10;
                if (grant_drop) grant_dropped = 1'b1;
            end
            if (bus_if.bus_data_out != '0) begin
                wdata_cycles++;
                chk("wdata", bus_if.bus_data_out, cur_data);
            end
            if (bus_if.resp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_resp", bus_if.resp_valid, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_snoop", bus_if.resp_snoop, e.snoop);
                    chk("resp_data", bus_if.resp_data, e.data);
                    if (e.lat >= 0) chk("resp_latency", cyc - acc_cyc, e.lat);
                end
            end
        end
    end

    task automatic reset_checks(input string tag);
        chk({tag, "_req_ready"}, bus_if.req_ready, 1'b1);
        chk({tag, "_resp_valid"}, bus_if.resp_valid, 1'b0);
        chk({tag, "_resp_snoop"}, bus_if.resp_snoop, 2'b10);
        chk({tag, "_resp_data"}, bus_if.resp_data, '0);
        chk({tag, "_bus_req"}, bus_if.bus_req, 1'b0);
        chk({tag, "_bus_op"}, bus_if.bus_op, 8'h00);
        chk({tag, "_bus_addr"}, bus_if.bus_addr, 32'h0);
        chk({tag, "_bus_data_out"}, bus_if.bus_data_out, '0);
    endtask

    task automatic issue(input logic [7:0] op, input logic [31:0] addr, input logic [511:0] data,
                         input logic [1:0] es, input logic [511:0] ed, input int lat, input bit push);
        int n = 0;
        while (!bus_if.req_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_before_issue", bus_if.req_ready, 1'b1);
        cur_op = op;
        cur_addr = addr;
        cur_data = data;
        if (push) exp_q.push_back('{snoop: es, data: ed, lat: lat});
        bus_if.req_valid = 1'b1;
        bus_if.req_op = op;
        bus_if.req_addr = addr;
        bus_if.req_data = data;
        @(posedge clk); #1;
        bus_if.req_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || !bus_if.req_ready) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_done"}, (exp_q.size() == 0) && bus_if.req_ready, 1'b1);
    endtask

    task automatic txn(input string name, input logic [7:0] op, input logic [31:0] addr,
                       input logic [511:0] data, input logic [1:0] es, input logic [511:0] ed,
                       input int lat, input int n_addr, input int n_wd, input int n_bk);
        int a0 = addr_phases;
        int w0 = wdata_cycles;
        int b0 = bk_low;
        issue(op, addr, data, es, ed, lat, 1'b1);
        wait_done(name);
        chk({name, "_addr_phases"}, addr_phases - a0, n_addr);
        chk({name, "_wdata_cycles"}, wdata_cycles - w0, n_wd);
        chk({name, "_backoff_cycles"}, bk_low - b0, n_bk);
    endtask

    initial begin
        int a0;
        int r0;
        int n;
        bus_if.req_valid = 1'b0;
        bus_if.req_op = '0;
        bus_if.req_addr = '0;
        bus_if.req_data = '0;
        bus_if.bus_data_in = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_checks("rst");
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_release", bus_if.req_ready, 1'b1);

        bus_if.bus_data_in = 512'hA5;
        snoop_script.push_back(2'b10);
        txn("rd", 8'h52, 32'h0000_1000, '0, 2'b10, 512'hA5, BASE_LAT, 1, 0, 0);

        snoop_script.push_back(2'b00);
        txn("wr", 8'h57, 32'h0000_2040, 512'h1234, 2'b00, 512'hA5, BASE_LAT, 1, 1, 0);

        bus_if.bus_data_in = 512'hBEEF;
`ifdef SNOOP_RETRY_EN
        snoop_script.push_back(2'b01);
        snoop_script.push_back(2'b01);
        snoop_script.push_back(2'b10);
        txn("rfo_retry", 8'h4D, 32'h0000_3000, '0, 2'b10, 512'hBEEF, 17, 3, 0, 2 * SW);
        repeat (4) snoop_script.push_back(2'b01);
        txn("rd_retry_max", 8'h52, 32'h0000_4000, '0, 2'b01, 512'hBEEF, 23, 4, 0, 3 * SW);
`else
        snoop_script.push_back(2'b01);
        txn("rfo_hitm", 8'h4D, 32'h0000_3000, '0, 2'b01, 512'hBEEF, BASE_LAT, 1, 0, 0);
        snoop_script.push_back(2'b01);
        txn("rd_hitm", 8'h52, 32'h0000_4000, '0, 2'b01, 512'hBEEF, BASE_LAT, 1, 0, 0);
`endif

        snoop_script.push_back(2'b00);
        txn("inv_hit", 8'h49, 32'h0000_5000, '0, 2'b00, 512'hBEEF, BASE_LAT - 1, 1, 0, 0);

        grant_drop = 1'b1;
        snoop_script.push_back(2'b01);
        txn("inv_hitm_gdrop", 8'h49, 32'h0000_5040, '0, 2'b01, 512'hBEEF, BASE_LAT - 1, 1, 0, 0);
        grant_drop = 1'b0;

        r0 = req_cycles;
        txn("illegal", 8'h58, 32'h0000_6000, '0, 2'b11, 512'hBEEF, 0, 0, 0, 0);
        chk("illegal_no_bus_req", req_cycles - r0, 0);

        grant_main = 1'b0;
        bus_if.bus_data_in = 512'h77;
        snoop_script.push_back(2'b10);
        a0 = addr_phases;
        issue(8'h52, 32'h0000_7000, '0, 2'b10, 512'h77, BASE_LAT + 5, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        chk("grant_low_no_addr", addr_phases - a0, 0);
        chk("grant_low_bus_req", bus_if.bus_req, 1'b1);
        grant_main = 1'b1;
        wait_done("grant_late");
        chk("grant_late_addr_phases", addr_phases - a0, 1);

        snoop_script.push_back(2'b00);
        a0 = addr_phases;
        issue(8'h57, 32'h0000_8000, 512'h9999, 2'b00, '0, -1, 1'b0);
        n = 0;
        while (addr_phases == a0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("abort_reached_snoop", addr_phases - a0, 1);
        rst_n = 1'b0;
        #1;
        reset_checks("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        snoop_script.delete();
        repeat (10) @(posedge clk);
        #1;
        reset_checks("post_abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/shared_bus_master.md
SHARED_BUS_MASTER -- requirements
Module: shared_bus_master

Interface
REQ-001 SHALL have parameter SNOOP_WAIT, default 2: cycles from address phase to snoop-result sample (1..15).
REQ-002 SHALL have parameter MAX_RETRY, default 3: HITM re-issues allowed per request (1..7).
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have ports req_valid in 1, req_ready out 1: L2-side request handshake; accepted when both are high at a clock edge.
REQ-006 SHALL have ports req_op in 8, req_addr in 32, req_data in 512: ASCII op 'R' read, 'W' write, 'M' read-for-ownership, 'I' invalidate; address; write data.
REQ-007 SHALL have ports resp_valid out 1, resp_snoop out 2, resp_data out 512: one-cycle completion pulse, final snoop result, read data.
REQ-008 SHALL have ports bus_req out 1, bus_grant in 1: shared-bus arbitration.
REQ-009 SHALL have ports bus_op out 8, bus_addr out 32, bus_data_out out 512, bus_data_in in 512, snoop_in in 2: shared operation bus, address, data and snoop bus (00 HIT, 01 HITM, 10 NOHIT).

Function
REQ-010 SHALL implement FSM IDLE, ARB, ADDR, SNOOP, BACKOFF, DATA, RESP.
REQ-011 IDLE: req_ready=1; on accept, latch op/addr/data, go to ARB; all other states req_ready=0.
REQ-012 Illegal req_op (not R/W/M/I) SHALL go IDLE->RESP, no bus activity, resp_snoop=11.
REQ-013 ARB: bus_req=1 until bus_grant sampled high, then ADDR; bus_req stays 1 through RESP.
REQ-014 ADDR: exactly one cycle driving bus_op=latched op and bus_addr=latched addr; bus_op=8'h00 in every other state.
REQ-015 SNOOP: wait SNOOP_WAIT cycles after ADDR, sample snoop_in on the last one; 11 sampled is treated as NOHIT.
REQ-016 HIT or NOHIT: 'R'/'M'/'W' go to DATA; 'I' goes to RESP.
REQ-017 HITM on 'R'/'M': see Configuration; HITM on 'W'/'I' goes to DATA/RESP as in REQ-016.
REQ-018 DATA: one cycle; 'W' drives bus_data_out=latched data, 'R'/'M' capture bus_data_in into resp_data; bus_data_out=0 outside DATA.
REQ-019 RESP: resp_valid=1 for exactly one cycle with resp_snoop=last sampled result, then IDLE; bus_req drops entering IDLE.
REQ-020 Latency with grant already high, no retry: accept edge to resp_valid = 3+SNOOP_WAIT cycles (ARB, ADDR, SNOOP_WAIT, DATA, RESP pipelined as stated).
REQ-021 Loss of bus_grant after ARB SHALL be ignored until RESP completes.
REQ-022 resp_data SHALL hold its last value until the next read capture.

Reset
REQ-023 rst_n low SHALL immediately force IDLE, retry count 0, req_ready=1 on release, resp_valid=0, resp_snoop=10, resp_data=0, bus_req=0, bus_op=8'h00, bus_addr=0, bus_data_out=0.
REQ-024 Reset mid-transaction SHALL abandon it with no response pulse.

Configuration
REQ-025 With SNOOP_RETRY_EN defined, HITM on 'R'/'M' SHALL enter BACKOFF for SNOOP_WAIT cycles with bus_req=0, increment retry count, return to ARB; after MAX_RETRY retries the next HITM SHALL proceed to DATA and report resp_snoop=01.
REQ-026 Without SNOOP_RETRY_EN, HITM on 'R'/'M' SHALL proceed directly to DATA and report 01; BACKOFF state and retry counter absent.
REQ-027 Retry count SHALL clear on every accept.

Verification
REQ-028 'R' @32'h0000_1000, grant high, snoop 10, bus_data_in=512'hA5 -> bus_op 'R' one cycle, resp_valid at cycle 3+SNOOP_WAIT, resp_snoop 10, resp_data 512'hA5.
REQ-029 'W' @32'h0000_2040, data 512'h1234, snoop 00 -> bus_data_out 512'h1234 in DATA cycle only, resp_snoop 00.
REQ-030 'M' with snoop 01 twice then 10, SNOOP_RETRY_EN defined -> three ADDR phases, bus_req low during each BACKOFF, resp_snoop 10; undefined -> one ADDR phase, resp_snoop 01.
REQ-031 req_op 'X' -> resp_valid next cycle, resp_snoop 11, bus_req never asserted.
REQ-032 grant held low 5 cycles, then rst_n pulsed low during SNOOP of the next request -> no ADDR until grant, after reset all outputs at REQ-023 values, no resp_valid.
